// File: rtl/multi_button_control.sv
// Per-channel synchroniser, debounce counter and one-vote-per-press lockout.
// Accepts a vote only when exactly one button qualifies and no other is held.
module multi_button_control #(
    parameter int unsigned NUM_BUTTONS = 4,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH   = 11,
    parameter int unsigned IDX_WIDTH   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button,
    input  logic                   enable,
    output logic [NUM_BUTTONS-1:0] valid_vote,
    output logic [IDX_WIDTH-1:0]   vote_index,
    output logic                   vote_any,
    output logic                   conflict,
    output logic                   locked
);

    localparam logic [CNT_WIDTH-1:0] HOLD_CNT = CNT_WIDTH'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] SAT_CNT  = CNT_WIDTH'(HOLD_CYCLES + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NUM_BUTTONS-1:0] b_meta;
    logic [NUM_BUTTONS-1:0] b_s;
    logic [CNT_WIDTH-1:0]   cnt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] q;
    logic [IDX_WIDTH-1:0]   q_idx;
    logic                   q_onehot;
    logic                   vote_ok;
    logic [NUM_BUTTONS-1:0] valid_vote_d;
    logic [IDX_WIDTH-1:0]   vote_index_d;
    logic                   vote_any_d;
    logic                   conflict_d;

    // Two-flop synchroniser for the raw buttons
    always_ff @(posedge clock) begin
        if (!reset) begin
            b_meta <= '0;
            b_s    <= '0;
        end else begin
            b_meta <= button;
            b_s    <= b_meta;
        end
    end

    // Saturating hold counters; saturation makes each hold qualify only once
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            if (!reset || !enable || !b_s[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] < SAT_CNT) begin
                cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        q     = '0;
        q_idx = '0;
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            q[i] = (cnt[i] == HOLD_CNT) && enable && (state == IDLE);
        end
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            if (q[i]) begin
                q_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign q_onehot = (q != '0) && ((q & (q - NUM_BUTTONS'(1))) == '0);
    assign vote_ok  = q_onehot && ((b_s & ~q) == '0);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the lock only releases once every button is up
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (q != '0) state_next = LOCKED;
            LOCKED:  if (b_s == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        valid_vote_d = '0;
        vote_index_d = vote_index;
        vote_any_d   = 1'b0;
        conflict_d   = 1'b0;
        if (state == IDLE && q != '0) begin
            if (vote_ok) begin
                valid_vote_d = q;
                vote_index_d = q_idx;
                vote_any_d   = 1'b1;
            end else begin
                conflict_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_vote <= '0;
            vote_index <= '0;
            vote_any   <= 1'b0;
            conflict   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            valid_vote <= valid_vote_d;
            vote_index <= vote_index_d;
            vote_any   <= vote_any_d;
            conflict   <= conflict_d;
            locked     <= (state_next == LOCKED);
        end
    end

endmodule

// File: tb/tb_multi_button_control.sv
// Directed bench for multi_button_control with HOLD_CYCLES=10, NUM_BUTTONS=4.
// Expected cycle numbers are counted in clock edges after the stimulus change.
module tb_multi_button_control;

    logic       clock;
    logic       reset;
    logic [3:0] button;
    logic       enable;
    logic [3:0] valid_vote;
    logic [1:0] vote_index;
    logic       vote_any;
    logic       conflict;
    logic       locked;

    int checks;
    int errors;
    int cyc;
    int votes;
    int conflicts;
    int first_vote;
    int lock_seen;
    int pulse_err;
    logic [3:0] last_vv;
    logic [1:0] last_idx;

    multi_button_control #(
        .NUM_BUTTONS(4),
        .HOLD_CYCLES(10),
        .CNT_WIDTH  (11),
        .IDX_WIDTH  (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .button    (button),
        .enable    (enable),
        .valid_vote(valid_vote),
        .vote_index(vote_index),
        .vote_any  (vote_any),
        .conflict  (conflict),
        .locked    (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        cyc        = 0;
        votes      = 0;
        conflicts  = 0;
        first_vote = 0;
        lock_seen  = 0;
        last_vv    = '0;
        last_idx   = '0;
    endtask

    // Advance n cycles, collecting pulse statistics
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            cyc++;
            if (vote_any) begin
                votes++;
                if (first_vote == 0) first_vote = cyc;
                last_vv  = valid_vote;
                last_idx = vote_index;
            end
            if (conflict) conflicts++;
            if (locked) lock_seen++;
            if (vote_any != (|valid_vote)) pulse_err++;
            if (conflict && valid_vote != 4'b0000) pulse_err++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pulse_err = 0;
        reset     = 1'b0;
        button    = 4'b0000;
        enable    = 1'b1;
        clear_stats();

        tick();
        tick();
        check("rst_valid_vote", 32'(valid_vote), 0);
        check("rst_vote_index", 32'(vote_index), 0);
        check("rst_vote_any",   32'(vote_any),   0);
        check("rst_conflict",   32'(conflict),   0);
        check("rst_locked",     32'(locked),     0);
        reset = 1'b1;
        run(3);

        // Single clean press of button 2
        clear_stats();
        button = 4'b0100;
        run(30);
        check("b2_votes",      32'(votes),      1);
        check("b2_first",      32'(first_vote), 13);
        check("b2_valid_vote", 32'(last_vv),    4);
        check("b2_index",      32'(last_idx),   2);
        check("b2_conflicts",  32'(conflicts),  0);
        check("b2_locked",     32'(locked),     1);
        button = 4'b0000;
        run(2);
        check("b2_locked_rel2", 32'(locked), 1);
        run(1);
        check("b2_locked_rel3", 32'(locked), 0);
        run(3);

        // Short hold of button 1
        clear_stats();
        button = 4'b0010;
        run(8);
        button = 4'b0000;
        run(8);
        check("short_votes", 32'(votes),     0);
        check("short_lock",  32'(lock_seen), 0);

        // Boundary: 9 cycles nothing, 10 cycles qualifies
        clear_stats();
        button = 4'b0001;
        run(9);
        button = 4'b0000;
        run(8);
        check("hold9_votes", 32'(votes), 0);
        clear_stats();
        button = 4'b0001;
        run(10);
        button = 4'b0000;
        run(8);
        check("hold10_votes", 32'(votes),      1);
        check("hold10_first", 32'(first_vote), 13);
        check("hold10_index", 32'(last_idx),   0);
        check("hold10_unlock", 32'(locked),    0);

        // Button 0 held, button 3 joins: conflict, no vote
        clear_stats();
        button = 4'b0001;
        run(5);
        button = 4'b1001;
        run(30);
        check("cf_conflicts", 32'(conflicts), 1);
        check("cf_votes",     32'(votes),     0);
        check("cf_locked",    32'(locked),    1);
        button = 4'b1000;
        run(15);
        check("cf_locked_b3", 32'(locked),    1);
        check("cf_conflicts2", 32'(conflicts), 1);
        button = 4'b0000;
        run(4);
        check("cf_unlocked", 32'(locked), 0);

        // Long hold, short release, re-hold of button 1
        clear_stats();
        button = 4'b0010;
        run(100);
        button = 4'b0000;
        run(5);
        button = 4'b0010;
        run(20);
        button = 4'b0000;
        run(5);
        check("rehold_votes", 32'(votes),   2);
        check("rehold_vv",    32'(last_vv), 2);
        check("rehold_index", 32'(last_idx), 1);

        // Reset at count 7 of a button 3 hold
        clear_stats();
        button = 4'b1000;
        run(9);
        reset = 1'b0;
        tick();
        check("mid_rst_vv",       32'(valid_vote), 0);
        check("mid_rst_any",      32'(vote_any),   0);
        check("mid_rst_conflict", 32'(conflict),   0);
        check("mid_rst_locked",   32'(locked),     0);
        reset  = 1'b1;
        button = 4'b0000;
        run(20);
        check("mid_rst_votes", 32'(votes), 0);

        // Enable low during hold, then raised mid-hold
        clear_stats();
        enable = 1'b0;
        button = 4'b0001;
        run(30);
        check("en_off_votes", 32'(votes), 0);
        clear_stats();
        enable = 1'b1;
        run(20);
        check("en_on_votes", 32'(votes),      1);
        check("en_on_first", 32'(first_vote), 11);
        check("en_on_vv",    32'(last_vv),    1);
        enable = 1'b0;
        run(5);
        check("en_off_keeps_lock", 32'(locked), 1);
        button = 4'b0000;
        run(3);
        check("en_off_release", 32'(locked), 0);
        enable = 1'b1;
        run(3);

        check("pulse_shape", 32'(pulse_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
